// File: rtl/alu_flag_unit_if.sv
// Operation/flag bus of the ALU flag stage; master drives operations, slave is the stage.

interface alu_flag_unit_if #(
    parameter int W     = 4,
    parameter int OPW   = 4,
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   opcode;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [W-1:0]     op_result;
    logic             cout_in;
    logic [3:0]       flag_en;
    logic             out_valid;
    logic             out_ready;
    logic             negative;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             sticky_c;
    logic             sticky_v;
    logic             sticky_clr;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, opcode, op_a, op_b, op_result, cout_in, flag_en,
               out_ready, sticky_clr,
        input  in_ready, out_valid, negative, zero, cout, overflow,
               sticky_c, sticky_v, ovf_count
    );

    modport slave (
        input  in_valid, opcode, op_a, op_b, op_result, cout_in, flag_en,
               out_ready, sticky_clr,
        output in_ready, out_valid, negative, zero, cout, overflow,
               sticky_c, sticky_v, ovf_count
    );
endinterface

// File: rtl/alu_flag_unit.sv
// Flag stage behind the ALU result path: N/Z/C/V generation, an architectural flag
// register with per-flag enables, sticky C/V and a saturating overflow-event counter.

package alu_ops;
    localparam logic [3:0] ADD_OP = 4'h0;
    localparam logic [3:0] SUB_OP = 4'h1;
endpackage

module alu_flag_unit #(
    parameter int W     = 4,
    parameter int OPW   = 4,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    alu_flag_unit_if.slave bus
);

    typedef enum logic {EMPTY, FULL} stage_t;

    stage_t           state;
    logic             accept;
    logic             is_add;
    logic             is_sub;
    logic             a_msb;
    logic             b_msb;
    logic             r_msb;
    logic             n_new;
    logic             z_new;
    logic             c_new;
    logic             v_new;
    logic             negative_q;
    logic             zero_q;
    logic             cout_q;
    logic             overflow_q;
    logic             sticky_c_q;
    logic             sticky_v_q;
    logic [CNT_W-1:0] ovf_count_q;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_operand_bits;

    assign bus.in_ready = (state == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign is_add = (bus.opcode == OPW'(alu_ops::ADD_OP));
    assign is_sub = (bus.opcode == OPW'(alu_ops::SUB_OP));
    assign a_msb  = bus.op_a[W-1];
    assign b_msb  = bus.op_b[W-1];
    assign r_msb  = bus.op_result[W-1];

    // Only the sign bits of the operands matter for overflow detection.
    assign unused_operand_bits = ^{bus.op_a[W-2:0], bus.op_b[W-2:0]};

    always_comb begin
        n_new = r_msb;
        z_new = (bus.op_result == '0);
        c_new = 1'b0;
        v_new = 1'b0;
        if (is_add) begin
            c_new = bus.cout_in;
            v_new = (a_msb == b_msb) && (r_msb != a_msb);
        end else if (is_sub) begin
            c_new = bus.cout_in;
            v_new = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    // A clear coinciding with an accept wipes the old count before the new event lands.
    always_comb begin
        cnt_base = bus.sticky_clr ? '0 : ovf_count_q;
        cnt_next = cnt_base;
        if (accept && v_new && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            sticky_c_q  <= 1'b0;
            sticky_v_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (!accept && bus.out_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                if (bus.flag_en[3]) negative_q <= n_new;
                if (bus.flag_en[2]) zero_q     <= z_new;
                if (bus.flag_en[1]) cout_q     <= c_new;
                if (bus.flag_en[0]) overflow_q <= v_new;
            end
            if (accept || bus.sticky_clr) begin
                sticky_c_q  <= (sticky_c_q & ~bus.sticky_clr) | (accept & c_new);
                sticky_v_q  <= (sticky_v_q & ~bus.sticky_clr) | (accept & v_new);
                ovf_count_q <= cnt_next;
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.sticky_c  = sticky_c_q;
    assign bus.sticky_v  = sticky_v_q;
    assign bus.ovf_count = ovf_count_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: two instances (CNT_W=8 and CNT_W=2) driven in lockstep.

module tb_alu_flag_unit;

    localparam logic [3:0] OP_ADD   = alu_ops::ADD_OP;
    localparam logic [3:0] OP_SUB   = alu_ops::SUB_OP;
    localparam logic [3:0] OP_OTHER = 4'h5;

    typedef struct {
        logic n, z, c, v, sc, sv;
        int   cnt8;
        int   cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    logic m_n, m_z, m_c, m_v, m_sc, m_sv;
    int   m_cnt8, m_cnt2;

    alu_flag_unit_if #(.W(4), .OPW(4), .CNT_W(8)) ifc8 ();
    alu_flag_unit_if #(.W(4), .OPW(4), .CNT_W(2)) ifc2 ();

    alu_flag_unit #(.W(4), .OPW(4), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    alu_flag_unit #(.W(4), .OPW(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

    assign ifc2.in_valid   = ifc8.in_valid;
    assign ifc2.opcode     = ifc8.opcode;
    assign ifc2.op_a       = ifc8.op_a;
    assign ifc2.op_b       = ifc8.op_b;
    assign ifc2.op_result  = ifc8.op_result;
    assign ifc2.cout_in    = ifc8.cout_in;
    assign ifc2.flag_en    = ifc8.flag_en;
    assign ifc2.out_ready  = ifc8.out_ready;
    assign ifc2.sticky_clr = ifc8.sticky_clr;

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_n"},    32'(ifc8.negative),  32'(m_n));
        check_output({tag, "_z"},    32'(ifc8.zero),      32'(m_z));
        check_output({tag, "_c"},    32'(ifc8.cout),      32'(m_c));
        check_output({tag, "_v"},    32'(ifc8.overflow),  32'(m_v));
        check_output({tag, "_sc"},   32'(ifc8.sticky_c),  32'(m_sc));
        check_output({tag, "_sv"},   32'(ifc8.sticky_v),  32'(m_sv));
        check_output({tag, "_cnt8"}, 32'(ifc8.ovf_count), 32'(m_cnt8));
        check_output({tag, "_cnt2"}, 32'(ifc2.ovf_count), 32'(m_cnt2));
        check_output({tag, "_n2"},   32'(ifc2.negative),  32'(m_n));
        check_output({tag, "_v2"},   32'(ifc2.overflow),  32'(m_v));
    endtask

    task automatic model_reset();
        {m_n, m_z, m_c, m_v, m_sc, m_sv} = '0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    // Hand-computed new flags come in; the model applies enables, sticky and saturation.
    task automatic model_accept(input logic [3:0] en, input logic clr,
                                input logic xn, input logic xz, input logic xc, input logic xv);
        exp_t e;
        if (clr) begin
            m_sc = 1'b0; m_sv = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end
        m_sc = m_sc | xc;
        m_sv = m_sv | xv;
        if (xv) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        if (en[3]) m_n = xn;
        if (en[2]) m_z = xz;
        if (en[1]) m_c = xc;
        if (en[0]) m_v = xv;
        e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v;
        e.sc = m_sc; e.sv = m_sv; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] r, input logic cin, input logic [3:0] en,
                                  input logic clr,
                                  input logic xn, input logic xz, input logic xc, input logic xv);
        bit accepted = 1'b0;
        ifc8.opcode     = op;
        ifc8.op_a       = a;
        ifc8.op_b       = b;
        ifc8.op_result  = r;
        ifc8.cout_in    = cin;
        ifc8.flag_en    = en;
        ifc8.sticky_clr = clr;
        ifc8.in_valid   = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (ifc8.in_ready) begin
                accepted = 1'b1;
                model_accept(en, clr, xn, xz, xc, xv);
            end
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        @(posedge clk);
        #1;
        ifc8.in_valid   = 1'b0;
        ifc8.sticky_clr = 1'b0;
    endtask

    // Monitor: compare the presented flags whenever the consumer takes an output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ifc8.out_valid && ifc8.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got out_valid=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    check_output("mon_n",    32'(ifc8.negative),  32'(e.n));
                    check_output("mon_z",    32'(ifc8.zero),      32'(e.z));
                    check_output("mon_c",    32'(ifc8.cout),      32'(e.c));
                    check_output("mon_v",    32'(ifc8.overflow),  32'(e.v));
                    check_output("mon_sc",   32'(ifc8.sticky_c),  32'(e.sc));
                    check_output("mon_sv",   32'(ifc8.sticky_v),  32'(e.sv));
                    check_output("mon_cnt8", 32'(ifc8.ovf_count), 32'(e.cnt8));
                    check_output("mon_cnt2", 32'(ifc2.ovf_count), 32'(e.cnt2));
                    check_output("mon_valid2", 32'(ifc2.out_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        ifc8.in_valid   = 1'b0;
        ifc8.opcode     = '0;
        ifc8.op_a       = '0;
        ifc8.op_b       = '0;
        ifc8.op_result  = '0;
        ifc8.cout_in    = 1'b0;
        ifc8.flag_en    = '0;
        ifc8.out_ready  = 1'b1;
        ifc8.sticky_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("reset_out_valid", 32'(ifc8.out_valid), 32'd0);
        check_output("reset_in_ready",  32'(ifc8.in_ready),  32'd1);
        check_state("reset");
        @(posedge clk);
        #1;

        $display("[TB] basic ADD/SUB flag generation");
        apply_stimulus(OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 4'b1111, 1'b0, 1, 0, 0, 1);
        apply_stimulus(OP_SUB, 4'h0, 4'h1, 4'hF, 1'b0, 4'b1111, 1'b0, 1, 0, 0, 0);
        apply_stimulus(OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1, 4'b1111, 1'b0, 0, 0, 1, 1);

        $display("[TB] per-flag enables and non-arithmetic opcode");
        apply_stimulus(OP_ADD, 4'h4, 4'h4, 4'h8, 1'b0, 4'b1000, 1'b0, 1, 0, 0, 1);
        apply_stimulus(OP_OTHER, 4'h5, 4'h5, 4'h0, 1'b1, 4'b0100, 1'b0, 0, 1, 0, 0);

        $display("[TB] standalone sticky clear");
        @(posedge clk);
        #1;
        ifc8.sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        ifc8.sticky_clr = 1'b0;
        m_sc = 1'b0; m_sv = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        check_state("after_clr");

        $display("[TB] overflow counter saturation");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 4'b1111, 1'b0, 1, 0, 0, 1);
        end
        apply_stimulus(OP_ADD, 4'h1, 4'h1, 4'h2, 1'b0, 4'b1111, 1'b1, 0, 0, 0, 0);
        apply_stimulus(OP_ADD, 4'h9, 4'h9, 4'h2, 1'b1, 4'b1111, 1'b1, 0, 0, 1, 1);

        $display("[TB] back-pressure stall");
        @(posedge clk);
        #1;
        ifc8.out_ready = 1'b0;
        apply_stimulus(OP_ADD, 4'h2, 4'h3, 4'h5, 1'b0, 4'b1111, 1'b0, 0, 0, 0, 0);
        ifc8.opcode    = OP_SUB;
        ifc8.op_a      = 4'h5;
        ifc8.op_b      = 4'h3;
        ifc8.op_result = 4'h2;
        ifc8.cout_in   = 1'b1;
        ifc8.flag_en   = 4'b1111;
        ifc8.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_in_ready",  32'(ifc8.in_ready),  32'd0);
            check_output("stall_out_valid", 32'(ifc8.out_valid), 32'd1);
            check_output("stall_c",         32'(ifc8.cout),      32'(m_c));
        end
        @(posedge clk);
        #1;
        ifc8.out_ready = 1'b1;
        apply_stimulus(OP_SUB, 4'h5, 4'h3, 4'h2, 1'b1, 4'b1111, 1'b0, 0, 0, 1, 0);
        check_output("release_out_valid", 32'(ifc8.out_valid), 32'd1);

        $display("[TB] asynchronous reset during stall");
        @(posedge clk);
        #1;
        ifc8.out_ready = 1'b0;
        apply_stimulus(OP_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 4'b1111, 1'b0, 1, 0, 0, 1);
        check_output("pre_reset_n", 32'(ifc8.negative), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        check_output("async_out_valid", 32'(ifc8.out_valid), 32'd0);
        check_output("async_in_ready",  32'(ifc8.in_ready),  32'd1);
        check_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        ifc8.out_ready = 1'b1;
        #1;
        check_output("post_reset_in_ready", 32'(ifc8.in_ready), 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(OP_ADD, 4'h3, 4'h3, 4'h6, 1'b0, 4'b1111, 1'b0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check_output("queue_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Registered, parametrised flag stage that follows the ALU result path. It computes N/Z/C/V for each accepted operation, with real two's-complement overflow for `ADD_OP` and `SUB_OP`. It holds the architectural flag register with per-flag update enables, and keeps sticky carry/overflow flags plus a saturating overflow-event counter for status readout. It uses a single-entry valid/ready stage so it can sit in a back-pressured ALU pipeline.

## Interface
- `W`, 4: operand/result width.
- `OPW`, 4: opcode width; encodings are `alu_ops::ADD_OP` and `alu_ops::SUB_OP` from the `alu_ops` package.
- `CNT_W`, 8: width of the overflow-event counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: stage can accept.
- `opcode` in OPW: ALU operation.
- `op_a` in W: ALU operand A.
- `op_b` in W: ALU operand B.
- `op_result` in W: ALU result for A op B.
- `cout_in` in 1: carry/borrow out of the ALU adder for ADD/SUB.
- `flag_en` in 4: per-flag update enable, bit order {N,Z,C,V}.
- `out_valid` out 1: flags for an accepted op are available.
- `out_ready` in 1: consumer takes the output.
- `negative`, `zero`, `cout`, `overflow` out 1 each: architectural flag register.
- `sticky_c`, `sticky_v` out 1 each: OR of C and V results since the last clear.
- `sticky_clr` in 1: clear the sticky flags and the counter.
- `ovf_count` out CNT_W: number of accepted ops with V=1, saturating.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and allows full throughput.
- New flag values for an accepted op:
  - N_new = `op_result[W-1]`.
  - Z_new = (`op_result` == 0).
  - `ADD_OP`: C_new = `cout_in`; V_new = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
  - `SUB_OP`: C_new = `cout_in`; V_new = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
  - Any other opcode: C_new = 0, V_new = 0.
- On accept, each flag register bit loads its new value only if its `flag_en` bit is 1; otherwise it holds its previous value.
- Sticky flags and the counter use the computed C_new/V_new, regardless of `flag_en`:
  - `sticky_c |= C_new`.
  - `sticky_v |= V_new`.
  - `ovf_count` increments by 1 when V_new=1, and saturates at 2^CNT_W-1 (no wrap).
- `out_valid`:
  - Set on accept.
  - Cleared when `out_ready && !accept`.
  - Stays 1 when accept and `out_ready` occur in the same cycle.
- Flags change only on accept. While stalled (`out_valid && !out_ready`), all outputs hold.
- `sticky_clr` with no accept clears `sticky_c`, `sticky_v` and `ovf_count` to 0.
- `sticky_clr` coinciding with an accept: the clear applies first, then the new event.
  - `sticky_c` = C_new, `sticky_v` = V_new.
  - `ovf_count` = V_new ? 1 : 0.
- The internal state is a two-state stage: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `out_ready && !accept`.
  - FULL -> FULL otherwise.

## Timing
- Latency is 1 cycle: flags for an op accepted at edge k are visible after edge k and remain valid with `out_valid`=1.
- Throughput is 1 op/cycle while `out_ready`=1.
- Reset (asynchronous assert, synchronous deassert is handled outside the block). Reset values:
  - `out_valid`=0.
  - `negative`=0, `zero`=0, `cout`=0, `overflow`=0.
  - `sticky_c`=0, `sticky_v`=0.
  - `ovf_count`=0.
  - `in_ready`=1 (follows from `out_valid`=0).
- Reset mid-stall drops the pending output; no flag or counter retains pre-reset state.
- Inputs are sampled only on accept; `op_*`, `opcode`, `cout_in` and `flag_en` are don't-care otherwise.

## Test plan
- Reset, then ADD a=7, b=1, r=8, cout_in=0, flag_en=1111 -> next cycle: N=1, Z=0, C=0, V=1, sticky_v=1, ovf_count=1, out_valid=1.
- SUB a=0, b=1, r=F, cout_in=0, then SUB a=8, b=1, r=7, cout_in=1 (flag_en=1111) -> first: N=1, Z=0, C=0, V=0; second: N=0, Z=0, C=1, V=1, ovf_count increments.
- Non-ADD/SUB opcode, a=5, b=5, r=0, cout_in=1, flag_en=0100 after a state of N=1, C=1, V=1 -> Z=1, N/C/V unchanged at 1, sticky flags unchanged.
- Hold `out_ready`=0 with `out_valid`=1, present a new op -> `in_ready`=0, no accept, flags unchanged. Then raise `out_ready` with `in_valid`=1 -> accept in the same cycle, `out_valid` stays 1.
- CNT_W=2: five ADD 7+1 ops -> ovf_count sequence 1, 2, 3, 3, 3. Then `sticky_clr` together with an ADD 1+1 -> ovf_count=0, sticky_v=0, sticky_c=cout_in.
- Assert `rst_n`=0 asynchronously mid-stall with flags set -> all outputs return to their reset values immediately (before the next edge); `in_ready`=1 after release.
